id_ex_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 48 ++++
 rtl/fwd_mux.sv | 18 +
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALUFun codes, destination encodings and the ID/EX register layout.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int FUN_W  = 6;

    localparam logic [FUN_W-1:0] ALU_ADD = 6'b000000;
    localparam logic [FUN_W-1:0] ALU_SUB = 6'b000001;
    localparam logic [FUN_W-1:0] ALU_AND = 6'b011000;
    localparam logic [FUN_W-1:0] ALU_OR  = 6'b011110;
    localparam logic [FUN_W-1:0] ALU_SLT = 6'b110101;
    localparam logic [FUN_W-1:0] ALU_SLL = 6'b100000;
    localparam logic [FUN_W-1:0] ALU_SRL = 6'b100001;
    localparam logic [FUN_W-1:0] ALU_SRA = 6'b100011;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  shamt;
        logic [REG_W-1:0]  dst;
        logic [FUN_W-1:0]  alu_fun;
        logic              sign;
        logic              alusrc1;
        logic              alusrc2;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

    // Unused encoding 11 resolves to $0 so the instruction never writes back.
    function automatic logic [REG_W-1:0] sel_dst(input logic [1:0] reg_dst,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [REG_W-1:0] rd);
        return reg_dst == REG_DST_RT ? rt :
               reg_dst == REG_DST_RD ? rd :
               reg_dst == REG_DST_RA ? 5'd31 : 5'd0;
    endfunction
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: one forwarded operand; EX/MEM beats MEM/WB, $0 is never forwarded.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] data,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] fwd
);
    always_comb
        fwd = (exmem_reg_write && exmem_rd != '0 && exmem_rd == src) ? exmem_result :
              (memwb_reg_write && memwb_rd != '0 && memwb_rd == src) ? memwb_result : data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarded ALU operand selection
// and load-use hazard detection.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [REG_W-1:0]  id_shamt,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [FUN_W-1:0]  id_alu_fun,
    input  logic              id_sign,
    input  logic              id_alusrc1,
    input  logic              id_alusrc2,
    input  logic [1:0]        id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FUN_W-1:0]  alu_fun,
    output logic              alu_sign,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_dst,
    output logic [DATA_W-1:0] ex_pc4,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              load_use
);
    id_ex_t ex, nxt;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    always_comb begin
        nxt            = '0;
        nxt.valid      = id_valid;
        nxt.pc4        = id_pc4;
        nxt.rs_data    = id_rs_data;
        nxt.rt_data    = id_rt_data;
        nxt.imm        = id_imm_ext;
        nxt.rs         = id_rs;
        nxt.rt         = id_rt;
        nxt.shamt      = id_shamt;
        nxt.dst        = sel_dst(id_reg_dst, id_rt, id_rd);
        nxt.alu_fun    = id_alu_fun;
        nxt.sign       = id_sign;
        nxt.alusrc1    = id_alusrc1;
        nxt.alusrc2    = id_alusrc2;
        nxt.reg_write  = id_reg_write & id_valid;
        nxt.mem_read   = id_mem_read & id_valid;
        nxt.mem_write  = id_mem_write & id_valid;
        nxt.mem_to_reg = id_mem_to_reg & id_valid;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset)     ex <= '0;
        else if (flush) ex <= '0;
        else if (!stall) ex <= nxt;

    fwd_mux u_fwd_rs (
        .src(ex.rs), .data(ex.rs_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .fwd(fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .src(ex.rt), .data(ex.rt_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .fwd(fwd_rt)
    );

    always_comb begin
        alu_a         = ex.alusrc1 ? {27'b0, ex.shamt} : fwd_rs;
        alu_b         = ex.alusrc2 ? ex.imm : fwd_rt;
        alu_fun       = ex.alu_fun;
        alu_sign      = ex.sign;
        ex_store_data = fwd_rt;
        ex_dst        = ex.dst;
        ex_pc4        = ex.pc4;
        ex_reg_write  = ex.reg_write;
        ex_mem_read   = ex.mem_read;
        ex_mem_write  = ex.mem_write;
        ex_mem_to_reg = ex.mem_to_reg;
        load_use      = ex.valid & ex.mem_read & (ex.dst != '0) & (ex.dst == id_rs | ex.dst == id_rt);
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations for id_ex_stage.
module tb_id_ex_stage;
    logic        clk = 0, reset = 0, stall = 0, flush = 0;
    logic        id_valid;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_alu_fun;
    logic        id_sign, id_alusrc1, id_alusrc2;
    logic [1:0]  id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write = 0, memwb_reg_write = 0;
    logic [4:0]  exmem_rd = 0, memwb_rd = 0;
    logic [31:0] exmem_result = 0, memwb_result = 0;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc4;
    logic [5:0]  alu_fun;
    logic [4:0]  ex_dst;
    logic        alu_sign, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use;
    int          n_chk = 0, n_pass = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_imm_ext(id_imm_ext), .id_alu_fun(id_alu_fun), .id_sign(id_sign),
        .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_pc4(ex_pc4),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .load_use(load_use)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc4 = 0; id_rs_data = 0; id_rt_data = 0; id_imm_ext = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_alu_fun = 0; id_sign = 0;
        id_alusrc1 = 0; id_alusrc2 = 0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic set_add();
        clear_id();
        id_valid = 1; id_pc4 = 32'h104; id_rs = 1; id_rt = 2; id_rd = 3;
        id_rs_data = 5; id_rt_data = 7; id_alu_fun = 6'b000000;
        id_reg_dst = 2'b01; id_reg_write = 1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_fun"}, {26'b0, alu_fun}, 0);
        chk({tag, "_dst"}, {27'b0, ex_dst}, 0);
        chk({tag, "_pc4"}, ex_pc4, 0);
        chk({tag, "_ctrl"}, {alu_sign, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use}, 0);
    endtask

    initial begin
        clear_id();
        #12;
        check_zero("rst_init");
        @(negedge clk); reset = 1;

        set_add();
        tick();
        chk("add_a", alu_a, 5);
        chk("add_b", alu_b, 7);
        chk("add_dst", ex_dst, 3);
        chk("add_rw", ex_reg_write, 1);
        chk("add_pc4", ex_pc4, 32'h104);
        chk("add_store", ex_store_data, 7);

        exmem_reg_write = 1; exmem_rd = 1; exmem_result = 100;
        memwb_reg_write = 1; memwb_rd = 1; memwb_result = 200;
        #1 chk("fwd_exmem", alu_a, 100);
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", alu_a, 200);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        #1 chk("fwd_r0", alu_a, 5);
        memwb_rd = 2;
        #1 chk("fwd_rt_b", alu_b, 200);
        chk("fwd_rt_store", ex_store_data, 200);
        exmem_rd = 2;
        #1 chk("fwd_rt_prio", alu_b, 100);
        exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;

        clear_id();
        id_valid = 1; id_rt = 2; id_rd = 4; id_shamt = 8; id_rt_data = 1;
        id_alusrc1 = 1; id_alu_fun = 6'b100000; id_reg_dst = 2'b01; id_reg_write = 1;
        tick();
        chk("sll_a", alu_a, 8);
        chk("sll_b", alu_b, 1);
        chk("sll_fun", alu_fun, 6'b100000);
        chk("sll_dst", ex_dst, 4);

        clear_id();
        id_valid = 1; id_rs = 1; id_rt = 6; id_rs_data = 9; id_imm_ext = 32'hFFFF_FFFD;
        id_alusrc2 = 1; id_alu_fun = 6'b110101; id_sign = 1; id_reg_dst = 2'b00; id_reg_write = 1;
        id_rt_data = 32'h55;
        tick();
        chk("imm_b", alu_b, 32'hFFFF_FFFD);
        chk("imm_dst_rt", ex_dst, 6);
        chk("imm_sign", alu_sign, 1);
        chk("imm_store", ex_store_data, 32'h55);

        id_reg_dst = 2'b10;
        tick();
        chk("dst_ra", ex_dst, 31);
        id_reg_dst = 2'b11;
        tick();
        chk("dst_11", ex_dst, 0);

        id_valid = 0; id_reg_dst = 2'b01; id_mem_write = 1;
        tick();
        chk("inv_rw", ex_reg_write, 0);
        chk("inv_mw", ex_mem_write, 0);

        clear_id();
        id_valid = 1; id_rs = 1; id_rt = 5; id_imm_ext = 4; id_alusrc2 = 1;
        id_reg_dst = 2'b00; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        tick();
        chk("lw_mr", ex_mem_read, 1);
        chk("lw_m2r", ex_mem_to_reg, 1);
        clear_id();
        id_valid = 1; id_rs = 5; id_rt = 9;
        #1 chk("lu_rs", load_use, 1);
        id_rs = 7; id_rt = 5;
        #1 chk("lu_rt", load_use, 1);
        id_rt = 9;
        #1 chk("lu_none", load_use, 0);
        id_rs = 5;
        flush = 1;
        tick();
        flush = 0;
        chk("flush_rw", ex_reg_write, 0);
        chk("flush_mr", ex_mem_read, 0);
        chk("flush_lu", load_use, 0);

        set_add();
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_rs_data = 99 + i; id_rd = 10; id_alu_fun = 6'b000001; id_pc4 = 32'h200;
            tick();
            chk("stall_a", alu_a, 5);
            chk("stall_dst", ex_dst, 3);
            chk("stall_fun", alu_fun, 0);
        end
        flush = 1;
        tick();
        stall = 0; flush = 0;
        chk("sf_rw", ex_reg_write, 0);
        chk("sf_dst", ex_dst, 0);
        chk("sf_a", alu_a, 0);

        set_add();
        tick();
        chk("pre_rst_a", alu_a, 5);
        #2 reset = 0;
        #1 check_zero("rst_mid");
        @(negedge clk); reset = 1;
        tick();
        chk("post_rst_a", alu_a, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
